square_wave_meter: RTL and testbench



---
 rtl/square_wave_meter_pkg.sv | 13 +
 rtl/square_wave_meter_if.sv | 24 ++
 rtl/square_wave_meter_sync_edge_detect.sv | 29 ++
 rtl/square_wave_meter.sv | 130 +++++++++++++
 tb/tb_square_wave_meter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/square_wave_meter_pkg.sv
// Shared types and constants for the square-wave measurement block.
package sq_meter_pkg;

  typedef enum logic [1:0] {
    WARMUP,
    IDLE,
    HIGH,
    LOW
  } sq_state_t;

  localparam int unsigned WARMUP_CYCLES = 3;

endpackage

// File: rtl/square_wave_meter_if.sv
// Input and result bundle of square_wave_meter; master is the meter, slave the consumer.
interface square_wave_meter_if #(
  parameter int unsigned W = 16
);

  logic         sq_in;
  logic [W-1:0] high_len;
  logic [W-1:0] low_len;
  logic [W:0]   period;
  logic         valid;
  logic         sat;
  logic         stuck;

  modport master (
    input  sq_in,
    output high_len, low_len, period, valid, sat, stuck
  );

  modport slave (
    output sq_in,
    input  high_len, low_len, period, valid, sat, stuck
  );

endinterface

// File: rtl/square_wave_meter_sync_edge_detect.sv
// Two-flop synchroniser for an asynchronous level, with rise/fall strobes on the synchronised signal.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta;
  logic s;
  logic s_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      s    <= 1'b0;
      s_d  <= 1'b0;
    end else begin
      meta <= d;
      s    <= meta;
      s_d  <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/square_wave_meter.sv
// Measures high, low and period lengths of an asynchronous square wave in clk cycles.
module square_wave_meter
  import sq_meter_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic                clk,
  input  logic                reset,
  square_wave_meter_if.master bus
);

  localparam logic [W-1:0] CNT_MAX   = '1;
  localparam logic [W-1:0] CNT_ONE   = W'(1);
  localparam logic [1:0]   WARM_LAST = 2'(WARMUP_CYCLES - 1);

  logic rise;
  logic fall;

  sq_state_t    state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [1:0]   warm_q;
  logic         sat_now;
  logic         lat_high;
  logic         lat_low;
  logic         publish;

  logic [W-1:0] high_q;
  logic [W-1:0] low_q;
  logic [W:0]   period_q;
  logic         valid_q;
  logic         sat_q;
  logic         sat_h_q;
  logic         have_high_q;

  sync_edge_detect u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (bus.sq_in),
    .rise (rise),
    .fall (fall)
  );

  assign sat_now = (cnt_q == CNT_MAX);

  always_comb begin
    state_d  = state_q;
    cnt_d    = sat_now ? cnt_q : cnt_q + CNT_ONE;
    lat_high = 1'b0;
    lat_low  = 1'b0;
    publish  = 1'b0;
    case (state_q)
      WARMUP: begin
        cnt_d = '0;
        if (warm_q == WARM_LAST) state_d = IDLE;
      end
      IDLE: begin
        if (rise) begin
          state_d = HIGH;
          cnt_d   = CNT_ONE;
        end else if (fall) begin
          state_d = LOW;
          cnt_d   = CNT_ONE;
        end
      end
      HIGH: begin
        if (fall) begin
          lat_high = 1'b1;
          state_d  = LOW;
          cnt_d    = CNT_ONE;
        end
      end
      LOW: begin
        if (rise) begin
          lat_low = 1'b1;
          publish = have_high_q;
          state_d = HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      default: state_d = WARMUP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WARMUP;
      cnt_q   <= '0;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      warm_q  <= (state_q == WARMUP) ? warm_q + 2'd1 : '0;
    end
  end

  // The low-phase saturation flag is folded straight into sat at publish time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_q      <= '0;
      low_q       <= '0;
      period_q    <= '0;
      valid_q     <= 1'b0;
      sat_q       <= 1'b0;
      sat_h_q     <= 1'b0;
      have_high_q <= 1'b0;
    end else begin
      valid_q <= publish;
      if (lat_high) begin
        high_q      <= cnt_q;
        sat_h_q     <= sat_now;
        have_high_q <= 1'b1;
      end
      if (lat_low) begin
        low_q <= cnt_q;
      end
      if (publish) begin
        period_q <= {1'b0, high_q} + {1'b0, cnt_q};
        sat_q    <= sat_h_q | sat_now;
      end
    end
  end

  assign bus.high_len = high_q;
  assign bus.low_len  = low_q;
  assign bus.period   = period_q;
  assign bus.valid    = valid_q;
  assign bus.sat      = sat_q;
  assign bus.stuck    = sat_now && ((state_q == HIGH) || (state_q == LOW));

endmodule

// File: tb/tb_square_wave_meter.sv
// Scoreboard bench for square_wave_meter at W=16 and W=8.
module tb_square_wave_meter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  square_wave_meter_if #(.W(16)) if16 ();
  square_wave_meter_if #(.W(8))  if8 ();

  square_wave_meter #(.W(16)) dut16 (
    .clk  (clk),
    .reset(reset),
    .bus  (if16.master)
  );

  square_wave_meter #(.W(8)) dut8 (
    .clk  (clk),
    .reset(reset),
    .bus  (if8.master)
  );

  typedef struct {
    int unsigned h;
    int unsigned l;
    int unsigned p;
    bit          s;
    int unsigned cyc;
  } exp_t;

  exp_t        q16[$];
  exp_t        q8[$];
  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned cyc         = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // A rise driven at a negedge is sampled at the next posedge; valid shows two edges later.
  task automatic push16(input int unsigned h, input int unsigned l, input bit s);
    exp_t e;
    e.h = h; e.l = l; e.p = h + l; e.s = s; e.cyc = cyc + 3;
    q16.push_back(e);
  endtask

  task automatic push8(input int unsigned h, input int unsigned l, input bit s);
    exp_t e;
    e.h = h; e.l = l; e.p = h + l; e.s = s; e.cyc = cyc + 3;
    q8.push_back(e);
  endtask

  task automatic drive16(input logic lvl, input int unsigned n);
    if16.sq_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_zero16(input string tag);
    check({tag, "_high"},   32'(if16.high_len), 0);
    check({tag, "_low"},    32'(if16.low_len),  0);
    check({tag, "_period"}, 32'(if16.period),   0);
    check({tag, "_valid"},  32'(if16.valid),    0);
    check({tag, "_sat"},    32'(if16.sat),      0);
    check({tag, "_stuck"},  32'(if16.stuck),    0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (if16.valid) begin
      if (q16.size() == 0) begin
        check("spurious_valid16", 1, 0);
      end else begin
        e = q16.pop_front();
        check("high16",   32'(if16.high_len), e.h);
        check("low16",    32'(if16.low_len),  e.l);
        check("period16", 32'(if16.period),   e.p);
        check("sat16",    32'(if16.sat),      32'(e.s));
        check("vcyc16",   cyc,                e.cyc);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if8.valid) begin
      if (q8.size() == 0) begin
        check("spurious_valid8", 1, 0);
      end else begin
        e = q8.pop_front();
        check("high8",   32'(if8.high_len), e.h);
        check("low8",    32'(if8.low_len),  e.l);
        check("period8", 32'(if8.period),   e.p);
        check("sat8",    32'(if8.sat),      32'(e.s));
        check("vcyc8",   cyc,               e.cyc);
      end
    end
  end

  initial begin
    int unsigned c0;
    int unsigned off;

    reset      = 1'b1;
    if16.sq_in = 1'b0;
    if8.sq_in  = 1'b0;
    repeat (2) @(negedge clk);
    check_zero16("rst");
    check("rst_high8", 32'(if8.high_len), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 5/3 waveform, four published periods
    drive16(1'b1, 5);
    drive16(1'b0, 3);
    for (int i = 0; i < 4; i++) begin
      push16(5, 3, 1'b0);
      drive16(1'b1, 5);
      drive16(1'b0, 3);
    end
    repeat (6) @(negedge clk);
    check("pending_53", q16.size(), 0);

    // Input high across reset release: partial first phase is not reported
    if16.sq_in = 1'b1;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    drive16(1'b0, 4);
    drive16(1'b1, 6);
    drive16(1'b0, 2);
    push16(6, 2, 1'b0);
    drive16(1'b1, 5);
    drive16(1'b0, 3);
    repeat (6) @(negedge clk);
    check("pending_partial", q16.size(), 0);

    // Duty sweep down to single-cycle phases
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    drive16(1'b1, 1);
    drive16(1'b0, 1);
    push16(1, 1, 1'b0);
    drive16(1'b1, 1);
    drive16(1'b0, 7);
    push16(1, 7, 1'b0);
    drive16(1'b1, 7);
    drive16(1'b0, 1);
    push16(7, 1, 1'b0);
    drive16(1'b1, 4);
    drive16(1'b0, 4);
    repeat (4) @(negedge clk);
    check("pending_sweep", q16.size(), 0);

    // Reset in the middle of a high phase
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    drive16(1'b1, 5);
    drive16(1'b0, 3);
    push16(5, 3, 1'b0);
    drive16(1'b1, 5);
    drive16(1'b0, 3);
    push16(5, 3, 1'b0);
    drive16(1'b1, 4);
    check("pending_prerst", q16.size(), 0);
    check("prerst_period", 32'(if16.period), 8);
    reset = 1'b1;
    #1;
    check_zero16("midrst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    drive16(1'b0, 3);
    drive16(1'b1, 5);
    drive16(1'b0, 3);
    push16(5, 3, 1'b0);
    drive16(1'b1, 5);
    drive16(1'b0, 3);
    repeat (4) @(negedge clk);
    check("pending_postrst", q16.size(), 0);

    // W=8 saturation: high 300, low 10, then rise
    c0        = cyc;
    if8.sq_in = 1'b1;
    for (int i = 0; i < 310; i++) begin
      @(negedge clk);
      off = cyc - c0;
      check("stuck8", 32'(if8.stuck), 32'((off >= 257) && (off <= 302)));
      if (off == 300) if8.sq_in = 1'b0;
    end
    push8(255, 10, 1'b1);
    if8.sq_in = 1'b1;
    repeat (6) @(negedge clk);
    if8.sq_in = 1'b0;
    repeat (6) @(negedge clk);

    check("pending16", q16.size(), 0);
    check("pending8",  q8.size(),  0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
